// File: rtl/snake_pkg.sv
// Shared constants for the snake input controller and the graphics block that consumes it.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        SCREEN_TITLE = 2'd0,
        SCREEN_GAME  = 2'd3
    } screen_e;

    // Encoding pairs opposites on bit 0: up/down = 0/1, left/right = 2/3.
    function automatic dir_e opposite(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_input_ctrl_btn_debounce.sv
// One push-button channel: 2-flop synchroniser, consecutive-sample debounce, rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_0;
    logic          sync_1;
    logic          level;
    logic [CW-1:0] cnt;

    // NOTE: every register here uses <= so all flops sample the pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_0 <= btn;
            sync_1 <= sync_0;
            press  <= 1'b0;
            if (sync_1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This is the DEBOUNCE_CYCLES-th disagreeing sample: accept the new level.
                level <= sync_1;
                press <= sync_1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_input_ctrl.sv
// Button conditioning and game rules feeding the snake graphics block.
// Optional turn lock per snake step is enabled with `define SNAKE_TURN_LOCK_EN.
module snake_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP_CYCLES     = 4000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [3:0] moveState,
    output logic       isPaused,
    output logic [1:0] currentScreen,
    output logic       dir_changed
);

    if (DEBOUNCE_CYCLES < 2 || STEP_CYCLES < 1) begin : g_bad_params
        $error("snake_input_ctrl: DEBOUNCE_CYCLES must be >= 2 and STEP_CYCLES >= 1");
    end

    logic press_up, press_down, press_left, press_right, press_center;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up     (.clk(clk), .reset(reset), .btn(btn_up),     .press(press_up));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down   (.clk(clk), .reset(reset), .btn(btn_down),   .press(press_down));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_left   (.clk(clk), .reset(reset), .btn(btn_left),   .press(press_left));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right  (.clk(clk), .reset(reset), .btn(btn_right),  .press(press_right));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_center (.clk(clk), .reset(reset), .btn(btn_center), .press(press_center));

    screen_e screen_q;
    dir_e    dir_q;
    dir_e    ref_dir;
    dir_e    req_dir;
    logic    req_valid;
    logic    lock_ok;
    logic    accept;
    logic    change;

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_UP;
        if (press_up)         req_dir = DIR_UP;
        else if (press_down)  req_dir = DIR_DOWN;
        else if (press_left)  req_dir = DIR_LEFT;
        else if (press_right) req_dir = DIR_RIGHT;
        else                  req_valid = 1'b0;
    end

    // Only the highest-priority direction is judged; a rejected winner drops the rest.
    assign accept = req_valid && !press_center && (screen_q == SCREEN_GAME) && !isPaused
                    && lock_ok && (req_dir != opposite(ref_dir));
    assign change = accept && (req_dir != dir_q);

`ifdef SNAKE_TURN_LOCK_EN
    localparam int SW = $clog2(STEP_CYCLES + 1);

    logic [SW-1:0] step_cnt;
    logic          turned;

    always_ff @(posedge clk) begin
        if (reset || screen_q == SCREEN_TITLE) begin
            step_cnt <= '0;
            ref_dir  <= DIR_RIGHT;
            turned   <= 1'b0;
        end else if (!isPaused) begin
            if (step_cnt == SW'(STEP_CYCLES - 1)) begin
                step_cnt <= '0;
                ref_dir  <= change ? req_dir : dir_q;
                turned   <= 1'b0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
                if (change) turned <= 1'b1;
            end
        end
    end

    assign lock_ok = !turned;
`else
    assign ref_dir = dir_q;
    assign lock_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            screen_q    <= SCREEN_TITLE;
            dir_q       <= DIR_RIGHT;
            isPaused    <= 1'b1;
            dir_changed <= 1'b0;
        end else begin
            dir_changed <= 1'b0;
            case (screen_q)
                SCREEN_TITLE: begin
                    if (press_center) begin
                        screen_q <= SCREEN_GAME;
                        isPaused <= 1'b0;
                        dir_q    <= DIR_RIGHT;
                    end
                end
                SCREEN_GAME: begin
                    if (press_center) begin
                        isPaused <= !isPaused;
                    end else if (change) begin
                        dir_q       <= req_dir;
                        dir_changed <= 1'b1;
                    end
                end
                default: screen_q <= SCREEN_TITLE;
            endcase
        end
    end

    assign moveState     = {2'b00, dir_q};
    assign currentScreen = screen_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DEBOUNCE_CYCLES=4, STEP_CYCLES=16.
module tb_snake_input_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
    logic [3:0] moveState;
    logic       isPaused;
    logic [1:0] currentScreen;
    logic       dir_changed;

    int tests = 0;
    int fails = 0;

    snake_input_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_center(btn_center),
        .moveState(moveState), .isPaused(isPaused),
        .currentScreen(currentScreen), .dir_changed(dir_changed)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset defaults
        tick(3);
        check("rst_move",   moveState, 4'd3);
        check("rst_pause",  isPaused, 1'b1);
        check("rst_screen", currentScreen, 2'd0);
        check("rst_dchg",   dir_changed, 1'b0);
        reset = 1'b0;
        tick(2);

        // Direction presses in TITLE are ignored
        btn_up = 1'b1;  tick(8); btn_up = 1'b0;  tick(8);
        check("title_up_move", moveState, 4'd3);
        btn_left = 1'b1; tick(8); btn_left = 1'b0; tick(8);
        check("title_left_move",   moveState, 4'd3);
        check("title_left_screen", currentScreen, 2'd0);

        // 3-cycle glitch on center is rejected
        btn_center = 1'b1; tick(3); btn_center = 1'b0; tick(10);
        check("glitch_screen", currentScreen, 2'd0);
        check("glitch_pause",  isPaused, 1'b1);

        // Clean center press: GAME exactly 7 cycles after the edge
        btn_center = 1'b1;
        tick(6);
        check("entry_early_screen", currentScreen, 2'd0);
        tick(1);
        check("entry_screen", currentScreen, 2'd3);
        check("entry_pause",  isPaused, 1'b0);
        check("entry_move",   moveState, 4'd3);
        btn_center = 1'b0; tick(8);

        // Second press pauses, third unpauses
        btn_center = 1'b1; tick(7);
        check("pause_on", isPaused, 1'b1);
        btn_center = 1'b0; tick(8);
        btn_center = 1'b1; tick(7);
        check("pause_off", isPaused, 1'b0);
        btn_center = 1'b0; tick(8);

        // Reversal right->left rejected
        btn_left = 1'b1; tick(7);
        check("rev_left_move", moveState, 4'd3);
        check("rev_left_dchg", dir_changed, 1'b0);
        btn_left = 1'b0; tick(8);

        // Up accepted, dir_changed one cycle wide and aligned with moveState
        btn_up = 1'b1; tick(6);
        check("up_pre_dchg", dir_changed, 1'b0);
        tick(1);
        check("up_move", moveState, 4'd0);
        check("up_dchg", dir_changed, 1'b1);
        tick(1);
        check("up_dchg_drop", dir_changed, 1'b0);
        check("up_move_hold", moveState, 4'd0);
        btn_up = 1'b0; tick(8); tick(16);

        // Up -> left
        btn_left = 1'b1; tick(7);
        check("left_move", moveState, 4'd2);
        btn_left = 1'b0; tick(8); tick(16);

        // Up+left together: up wins
        btn_up = 1'b1; btn_left = 1'b1; tick(7);
        check("sim_up_left", moveState, 4'd0);
        btn_up = 1'b0; btn_left = 1'b0; tick(8); tick(16);

        // Down+left together: down wins and is rejected, left not tried
        btn_down = 1'b1; btn_left = 1'b1; tick(7);
        check("sim_down_left", moveState, 4'd0);
        btn_down = 1'b0; btn_left = 1'b0; tick(8); tick(16);

        // Center+left together: pause toggles, direction dropped
        btn_center = 1'b1; btn_left = 1'b1; tick(7);
        check("sim_ctr_pause", isPaused, 1'b1);
        check("sim_ctr_move",  moveState, 4'd0);
        btn_center = 1'b0; btn_left = 1'b0; tick(8);

        // Paused: direction discarded and not queued
        btn_right = 1'b1; tick(7);
        check("paused_right", moveState, 4'd0);
        btn_right = 1'b0; tick(8);
        btn_center = 1'b1; tick(7);
        check("unpause", isPaused, 1'b0);
        check("no_queue", moveState, 4'd0);
        btn_center = 1'b0; tick(8);

        // Turn lock sequence from a fresh GAME entry (step phase known)
        reset = 1'b1; tick(2); reset = 1'b0;
        btn_center = 1'b1; tick(7);
        check("tl_entry", currentScreen, 2'd3);
        btn_center = 1'b0;
        btn_up = 1'b1; tick(3);
        btn_left = 1'b1; tick(4);
        check("tl_up_move", moveState, 4'd0);
        check("tl_up_dchg", dir_changed, 1'b1);
        tick(3);
`ifdef SNAKE_TURN_LOCK_EN
        check("tl_left_locked", moveState, 4'd0);
        check("tl_left_dchg", dir_changed, 1'b0);
`else
        check("tl_left_free", moveState, 4'd2);
        check("tl_left_dchg", dir_changed, 1'b1);
`endif
        btn_up = 1'b0; btn_left = 1'b0; tick(8);
        btn_left = 1'b1; tick(7);
        check("tl_after_wrap", moveState, 4'd2);
`ifdef SNAKE_TURN_LOCK_EN
        check("tl_wrap_dchg", dir_changed, 1'b1);
`else
        check("tl_wrap_dchg", dir_changed, 1'b0);
`endif
        btn_left = 1'b0; tick(8);

        // Reset while btn_up bounces then holds
        btn_up = 1'b1; tick(1); btn_up = 1'b0; tick(1); btn_up = 1'b1; tick(2);
        reset = 1'b1; tick(1);
        check("mid_rst_move",   moveState, 4'd3);
        check("mid_rst_pause",  isPaused, 1'b1);
        check("mid_rst_screen", currentScreen, 2'd0);
        tick(1);
        reset = 1'b0;
        tick(5);
        check("held_press_early", dut.u_btn_up.press, 1'b0);
        tick(1);
        check("held_press", dut.u_btn_up.press, 1'b1);
        tick(3);
        check("held_title_move",   moveState, 4'd3);
        check("held_title_screen", currentScreen, 2'd0);
        check("held_title_dchg",   dir_changed, 1'b0);
        btn_up = 1'b0; tick(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
